// File: rtl/obsidian_pkg.sv
// rtl/obsidian_pkg.sv - shared opcode and flag-index constants for the Obsidian ALU
package obsidian_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_LSL = 4'b0100;
    localparam logic [3:0] ALU_LSR = 4'b0101;
    localparam logic [3:0] ALU_SAL = 4'b0110;
    localparam logic [3:0] ALU_SAR = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1001;

    // Bit positions inside the {N,Z,C,V} flag register
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/obsidian_shifter.sv
// rtl/obsidian_shifter.sv - barrel shifter for LSL/SAL, LSR and SAR
module obsidian_shifter
    import obsidian_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       shamt,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            ALU_LSL, ALU_SAL: y = a << shamt;
            ALU_LSR:          y = a >> shamt;
            ALU_SAR:          y = $unsigned($signed(a) >>> shamt);
            default:          y = a;
        endcase
    end

endmodule

// File: rtl/obsidian_alu.sv
// rtl/obsidian_alu.sv - 32-bit execute-stage ALU with registered result and NZCV flags
// Optional multiply on opcode 1001 when OBSIDIAN_ALU_MUL_EN is defined.
module obsidian_alu
    import obsidian_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    input  logic [4:0]       shamt,
    input  logic             flag_we,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic [WIDTH-1:0] c_q,
    output logic [3:0]       nzcv_q
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shift_y;
    logic             flag_c;
    logic             flag_v;
    logic [3:0]       nzcv_d;

    // Subtraction reuses the adder as a + ~b + 1 so carry-out means "no borrow"
    assign is_sub = (alu_control == ALU_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    obsidian_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .a     (a),
        .shamt (shamt),
        .op    (alu_control),
        .y     (shift_y)
    );

`ifdef OBSIDIAN_ALU_MUL_EN
    logic [WIDTH-1:0] mul_lo;
    assign mul_lo = a * b;
`endif

    always_comb begin
        c = '0;
        case (alu_control)
            ALU_ADD, ALU_SUB: c = sum[WIDTH-1:0];
            ALU_OR:           c = a | b;
            ALU_XOR:          c = a ^ b;
            ALU_AND:          c = a & b;
            ALU_LSL, ALU_LSR,
            ALU_SAL, ALU_SAR: c = shift_y;
`ifdef OBSIDIAN_ALU_MUL_EN
            ALU_MUL:          c = mul_lo;
`endif
            default:          c = '0;
        endcase
    end

    assign zero = (c == '0);

    always_comb begin
        flag_c = 1'b0;
        flag_v = 1'b0;
        if (alu_control == ALU_ADD) begin
            flag_c = sum[WIDTH];
            flag_v = (a[WIDTH-1] == b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
        end else if (is_sub) begin
            flag_c = sum[WIDTH];
            flag_v = (a[WIDTH-1] != b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_comb begin
        nzcv_d         = 4'b0000;
        nzcv_d[NZCV_N] = c[WIDTH-1];
        nzcv_d[NZCV_Z] = zero;
        nzcv_d[NZCV_C] = flag_c;
        nzcv_d[NZCV_V] = flag_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            nzcv_q <= 4'b0000;
        end else begin
            c_q <= c;
            if (flag_we) begin
                nzcv_q <= nzcv_d;
            end
        end
    end

endmodule

// File: tb/tb_obsidian_alu.sv
// tb/tb_obsidian_alu.sv - directed self-checking bench for obsidian_alu
module tb_obsidian_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [4:0]  shamt;
    logic        flag_we;
    logic [31:0] c;
    logic        zero;
    logic [31:0] c_q;
    logic [3:0]  nzcv_q;

    int checks = 0;
    int errors = 0;

    obsidian_alu #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .shamt       (shamt),
        .flag_we     (flag_we),
        .c           (c),
        .zero        (zero),
        .c_q         (c_q),
        .nzcv_q      (nzcv_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input logic we);
        alu_control = op;
        a           = av;
        b           = bv;
        shamt       = sh;
        flag_we     = we;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0);
        #2;
        check("reset_c_q", c_q, 32'h0);
        check("reset_nzcv", {28'h0, nzcv_q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD signed overflow
        drive(4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1);
        check("add_c", c, 32'h80000000);
        check("add_zero", {31'h0, zero}, 32'h0);
        tick();
        check("add_nzcv", {28'h0, nzcv_q}, 32'h9);
        check("add_c_q", c_q, 32'h80000000);

        // SUB equal operands
        drive(4'b0001, 32'h5, 32'h5, 5'd0, 1'b1);
        check("sub_c", c, 32'h0);
        check("sub_zero", {31'h0, zero}, 32'h1);
        tick();
        check("sub_nzcv", {28'h0, nzcv_q}, 32'h6);

        // SUB with borrow, then SUB with signed overflow
        drive(4'b0001, 32'h3, 32'h5, 5'd0, 1'b1);
        check("sub_borrow_c", c, 32'hFFFFFFFE);
        tick();
        check("sub_borrow_nzcv", {28'h0, nzcv_q}, 32'h8);
        drive(4'b0001, 32'h80000000, 32'h1, 5'd0, 1'b1);
        check("sub_ovf_c", c, 32'h7FFFFFFF);
        tick();
        check("sub_ovf_nzcv", {28'h0, nzcv_q}, 32'h3);

        // Shifts (b must be ignored)
        drive(4'b0100, 32'h80000001, 32'hFFFFFFFF, 5'd4, 1'b0);
        check("lsl", c, 32'h00000010);
        drive(4'b0101, 32'h80000001, 32'hFFFFFFFF, 5'd4, 1'b0);
        check("lsr", c, 32'h08000000);
        drive(4'b0111, 32'h80000001, 32'hFFFFFFFF, 5'd4, 1'b0);
        check("sar", c, 32'hF8000000);
        drive(4'b0110, 32'h80000001, 32'hFFFFFFFF, 5'd4, 1'b0);
        check("sal", c, 32'h00000010);
        drive(4'b0100, 32'h80000001, 32'hFFFFFFFF, 5'd0, 1'b0);
        check("lsl_sh0", c, 32'h80000001);
        drive(4'b0111, 32'h80000001, 32'hFFFFFFFF, 5'd31, 1'b0);
        check("sar_sh31", c, 32'hFFFFFFFF);
        drive(4'b0101, 32'h80000001, 32'hFFFFFFFF, 5'd31, 1'b0);
        check("lsr_sh31", c, 32'h00000001);

        // Logic ops; AND with flag_we gives N=1, C=V=0
        drive(4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b1);
        check("and", c, 32'hF000F000);
        tick();
        check("and_nzcv", {28'h0, nzcv_q}, 32'h8);
        drive(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0);
        check("or", c, 32'hFFF0FFF0);
        drive(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0);
        check("xor", c, 32'h0FF00FF0);
        drive(4'b1010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0);
        check("unused_c", c, 32'h0);
        check("unused_zero", {31'h0, zero}, 32'h1);

        // Multiply opcode, both build options
        drive(4'b1001, 32'h00010000, 32'h00010001, 5'd0, 1'b0);
`ifdef OBSIDIAN_ALU_MUL_EN
        check("mul", c, 32'h00010000);
`else
        check("mul_disabled", c, 32'h0);
`endif

        // flag_we=0: carry-producing ADD must not disturb nzcv_q (holds 1000 from AND)
        drive(4'b0000, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0);
        check("add_wrap_c", c, 32'h0);
        tick();
        check("hold_nzcv", {28'h0, nzcv_q}, 32'h8);
        check("wrap_c_q", c_q, 32'h0);

        // Load nonzero state, then assert reset between edges
        drive(4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1);
        tick();
        check("pre_rst_c_q", c_q, 32'h80000000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_c_q", c_q, 32'h0);
        check("async_rst_nzcv", {28'h0, nzcv_q}, 32'h0);
        tick();
        check("rst_held_c_q", c_q, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
